// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch_pkg / fetch
//
// This is the instruction-fetch stage of the five-stage RV64 pipeline.
// It owns the PC and keeps at most one instruction-bus request in flight.
// Each returned instruction goes to decode through the registered dataF slot.
// A one-entry skid buffer holds a response that arrives while decode is
// stalled. A decode redirect (branch && !stall) squashes the wrong-path fetch.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-low reset
//   ireq_valid     instruction request valid
//   ireq_addr      request address (the fetch PC)
//   iresp_addr_ok  bus accepted the request this cycle
//   iresp_data_ok  response data valid this cycle
//   iresp_data     instruction word
//   branch         decode redirect request
//   PCbranch       redirect target
//   stall          decode cannot accept dataF this cycle
//   dataF          {valid, pc, raw_instr} to decode
// -----------------------------------------------------------------------------
package fetch_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;
endpackage

module fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ireq_valid,
    output logic [63:0]            ireq_addr,
    input  logic                   iresp_addr_ok,
    input  logic                   iresp_data_ok,
    input  logic [31:0]            iresp_data,
    input  logic                   branch,
    input  logic [63:0]            PCbranch,
    input  logic                   stall,
    output fetch_pkg::fetch_data_t dataF
);
    import fetch_pkg::*;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_pc;        // next address to fetch
    logic [63:0] r_req_pc;    // address of the request in flight
    logic        r_kill;      // in-flight response belongs to the wrong path
    fetch_data_t r_skid;
    fetch_data_t r_dataF;

    logic        w_redir, w_slot_free, w_issue, w_resp, w_drop;
    logic        w_accept, w_load_out, w_load_skid, w_skid_out, w_still_out;
    logic [63:0] w_resp_pc;

    // A redirect while decode is stalled is ignored. Decode presents it again.
    assign w_redir     = branch & ~stall;
    assign w_slot_free = ~r_dataF.valid | ~stall;
    assign w_issue     = (r_state == S_REQ) & iresp_addr_ok;
    // A response can arrive in the same cycle as its addr_ok, in REQ.
    assign w_resp      = iresp_data_ok & ((r_state == S_WAIT) | w_issue);
    assign w_resp_pc   = (r_state == S_WAIT) ? r_req_pc : r_pc;
    // Drop a killed response. Also drop any response that lands in the cycle
    // decode redirects, because it is the sequential (wrong-path) instruction.
    assign w_drop      = ((r_state == S_WAIT) & r_kill) | w_redir;
    assign w_accept    = w_resp & ~w_drop;
    assign w_load_out  = w_accept & w_slot_free;
    assign w_load_skid = w_accept & ~w_slot_free;
    assign w_skid_out  = (r_state == S_HOLD) & ~stall & ~branch;
    // A request stays outstanding past this edge, so a redirect now must kill it.
    assign w_still_out = ~iresp_data_ok & (w_issue | (r_state == S_WAIT));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_REQ;
        else        r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ: begin
                if (iresp_addr_ok && !iresp_data_ok) w_next = S_WAIT;
                else if (w_load_skid)                w_next = S_HOLD;
            end
            S_WAIT: begin
                if (iresp_data_ok) w_next = w_load_skid ? S_HOLD : S_REQ;
            end
            S_HOLD: begin
                // A redirect also leaves HOLD. The skid entry is discarded below.
                if (!stall) w_next = S_REQ;
            end
            default: w_next = S_REQ;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gating with reset keeps the bus quiet while reset is held, even though
    // the state register already reads REQ.
    always_comb begin
        ireq_valid = (r_state == S_REQ) & reset;
        ireq_addr  = r_pc;
    end

    // ---------------- PC / in-flight tracking ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_kill   <= 1'b0;
        end else begin
            if (w_redir)      r_pc <= PCbranch;
            else if (w_issue) r_pc <= r_pc + 64'd4;   // wraps modulo 2^64

            if (w_issue && !iresp_data_ok) r_req_pc <= r_pc;

            if (w_redir && w_still_out)                     r_kill <= 1'b1;
            else if (r_state == S_WAIT && iresp_data_ok)    r_kill <= 1'b0;
        end
    end

    // ---------------- skid buffer and output slot ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid  <= '0;
            r_dataF <= '0;
        end else begin
            if (w_load_skid)
                r_skid <= '{valid: 1'b1, pc: w_resp_pc, raw_instr: iresp_data};
            else if (r_state == S_HOLD && !stall)
                r_skid.valid <= 1'b0;

            if (w_load_out)
                r_dataF <= '{valid: 1'b1, pc: w_resp_pc, raw_instr: iresp_data};
            else if (w_skid_out)
                r_dataF <= r_skid;
            else if (!stall)
                r_dataF.valid <= 1'b0;
        end
    end

    assign dataF = r_dataF;

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [63:0] R = 64'h0000_0000_8000_0000;

    typedef struct {
        logic        ao, dok;
        logic [31:0] data;
        logic        br;
        logic [63:0] pcb;
        logic        st;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_dv;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    logic        clk, reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        branch;
    logic [63:0] PCbranch;
    logic        stall;
    fetch_data_t dataF;

    int n_checks = 0;
    int n_fail   = 0;

    fetch #(.RESET_PC(R)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .branch(branch), .PCbranch(PCbranch), .stall(stall),
        .dataF(dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ao, dok, input logic [31:0] data,
                                input logic br, input logic [63:0] pcb, input logic st,
                                input logic e_rv, input logic [63:0] e_addr,
                                input logic e_dv, input logic [63:0] e_pc,
                                input logic [31:0] e_ins);
        vec_t v;
        v.ao = ao; v.dok = dok; v.data = data; v.br = br; v.pcb = pcb; v.st = st;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_dv = e_dv; v.e_pc = e_pc; v.e_ins = e_ins;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, then check the outputs
    // for that same cycle before the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        iresp_addr_ok = v.ao; iresp_data_ok = v.dok; iresp_data = v.data;
        branch = v.br; PCbranch = v.pcb; stall = v.st;
        #1;
        chk({tag, " ireq_valid"}, 64'(ireq_valid), 64'(v.e_rv));
        if (v.e_rv) chk({tag, " ireq_addr"}, ireq_addr, v.e_addr);
        chk({tag, " dataF.valid"}, 64'(dataF.valid), 64'(v.e_dv));
        if (v.e_dv) begin
            chk({tag, " dataF.pc"}, dataF.pc, v.e_pc);
            chk({tag, " dataF.instr"}, 64'(dataF.raw_instr), 64'(v.e_ins));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ireq_valid"}, 64'(ireq_valid), 64'd0);
        chk({tag, " dataF.valid"}, 64'(dataF.valid), 64'd0);
        chk({tag, " dataF.pc"}, dataF.pc, 64'd0);
        chk({tag, " dataF.instr"}, 64'(dataF.raw_instr), 64'd0);
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] I, A, Bv, A1, A2, DEAD, B1, B2, C1, C2, D1, E1, E2;
        logic [63:0] TOP;
        I = 32'h0000_0013; A = 32'h0010_0093; Bv = 32'h0020_0113;
        A1 = 32'h0030_0193; A2 = 32'h0040_0213; DEAD = 32'hdead_beef;
        B1 = 32'h0050_0293; B2 = 32'h0060_0313; C1 = 32'h0070_0393;
        C2 = 32'h0080_0413; D1 = 32'h0090_0493; E1 = 32'h00a0_0513;
        E2 = 32'h00b0_0593; TOP = 64'hFFFF_FFFF_FFFF_FFFC;

        //                ao dok data br pcb      st  rv addr      dv pc        ins
        // ideal bus
        tbl.push_back(mk(1, 1, I,  0, 0,       0,  1, R,        0, 0,        0));
        tbl.push_back(mk(1, 1, I,  0, 0,       0,  1, R+4,      1, R,        I));
        tbl.push_back(mk(1, 1, A,  0, 0,       0,  1, R+8,      1, R+4,      I));
        // response delayed 3 cycles after addr_ok
        tbl.push_back(mk(1, 0, 0,  0, 0,       0,  1, R+12,     1, R+8,      A));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  0, 0,        0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  0, 0,        0, 0,        0));
        tbl.push_back(mk(0, 1, Bv, 0, 0,       0,  0, 0,        0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, R+16,     1, R+12,     Bv));
        // 4-cycle stall with a response in flight -> skid
        tbl.push_back(mk(1, 1, A1, 0, 0,       0,  1, R+16,     0, 0,        0));
        tbl.push_back(mk(1, 0, 0,  0, 0,       1,  1, R+20,     1, R+16,     A1));
        tbl.push_back(mk(0, 1, A2, 0, 0,       1,  0, 0,        1, R+16,     A1));
        tbl.push_back(mk(0, 0, 0,  0, 0,       1,  0, 0,        1, R+16,     A1));
        tbl.push_back(mk(0, 0, 0,  0, 0,       1,  0, 0,        1, R+16,     A1));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  0, 0,        1, R+16,     A1));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, R+24,     1, R+20,     A2));
        // redirect while in WAIT: returned data is killed
        tbl.push_back(mk(1, 0, 0,  0, 0,       0,  1, R+24,     0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  1, R+256,   0,  0, 0,        0, 0,        0));
        tbl.push_back(mk(0, 1, DEAD,0, 0,      0,  0, 0,        0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, R+256,    0, 0,        0));
        tbl.push_back(mk(1, 1, B1, 0, 0,       0,  1, R+256,    0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, R+260,    1, R+256,    B1));
        // branch while stalled is ignored, dataF held
        tbl.push_back(mk(1, 1, B2, 0, 0,       0,  1, R+260,    0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  1, R+512,   1,  1, R+264,    1, R+260,    B2));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, R+264,    1, R+260,    B2));
        // redirect to the top of the address space, then wrap to 0
        tbl.push_back(mk(0, 0, 0,  1, TOP,     0,  1, R+264,    0, 0,        0));
        tbl.push_back(mk(1, 1, C1, 0, 0,       0,  1, TOP,      0, 0,        0));
        tbl.push_back(mk(1, 1, C2, 0, 0,       0,  1, 64'd0,    1, TOP,      C1));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, 64'd4,    1, 64'd0,    C2));
        // response landing in the redirect cycle is dropped
        tbl.push_back(mk(1, 1, D1, 1, R+768,   0,  1, 64'd4,    0, 0,        0));
        tbl.push_back(mk(0, 0, 0,  0, 0,       0,  1, R+768,    0, 0,        0));

        reset = 1'b0; iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1;
        iresp_data = DEAD; branch = 1'b0; PCbranch = '0; stall = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_zero("in_reset");
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release ireq_valid", 64'(ireq_valid), 64'd1);
        chk("release ireq_addr", ireq_addr, R);

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // reset asserted while a request is outstanding
        apply(mk(1, 0, 0, 0, 0, 0, 1, R+768, 0, 0, 0), "to_wait");
        @(negedge clk);
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        reset = 1'b0;
        #1 chk_zero("mid_reset");
        @(negedge clk);
        iresp_data_ok = 1'b1; iresp_data = DEAD;   // stale response must be ignored
        #1 chk_zero("mid_reset_resp");
        @(negedge clk);
        iresp_data_ok = 1'b0;
        reset = 1'b1;
        #1;
        chk("rerelease ireq_valid", 64'(ireq_valid), 64'd1);
        chk("rerelease ireq_addr", ireq_addr, R);

        // response under stall in REQ goes to skid, then a redirect empties HOLD
        apply(mk(1, 1, E1, 0, 0,     0, 1, R,      0, 0, 0),  "hold0");
        apply(mk(1, 1, E2, 0, 0,     1, 1, R+4,    1, R, E1), "hold1");
        apply(mk(0, 0, 0,  1, R+1280,0, 0, 0,      1, R, E1), "hold2");
        apply(mk(0, 0, 0,  0, 0,     0, 1, R+1280, 0, 0, 0),  "hold3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
